// File: rtl/port_in_debouncer_pkg.sv
// Shared I/O constants for the processor input port path.
// Imported by the debouncer and by the processor top level.
package port_in_debouncer_pkg;

    localparam int PORT_IN_WIDTH    = 8;
    localparam int DEBOUNCE_DEFAULT = 1000;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-flop synchronizer, mismatch counter,
// stable level register and a one-cycle change pulse.
module debounce_bit
    import port_in_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed long enough.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            level  <= 1'b0;
            change <= 1'b0;
        end else begin
            change <= 1'b0;
            if (sync2 != level) begin
                if (cnt == LAST) begin
                    level  <= sync2;
                    cnt    <= '0;
                    change <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/port_in_debouncer.sv
// Debounces the raw board inputs feeding the processor PortIn,
// with per-bit change pulses and a sticky change flag.
module port_in_debouncer
    import port_in_debouncer_pkg::*;
#(
    parameter int NBITS           = PORT_IN_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] RawIn,
    input  logic             ClearChange,
    output logic [NBITS-1:0] PortIn,
    output logic [NBITS-1:0] ChangePulse,
    output logic             AnyChange,
    output logic             ChangeLatched
);

    for (genvar i = 0; i < NBITS; i++) begin : gBit
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) uBit (
            .clk   (clk),
            .reset (reset),
            .raw   (RawIn[i]),
            .level (PortIn[i]),
            .change(ChangePulse[i])
        );
    end

    assign AnyChange = |ChangePulse;

    // Sticky flag; a new change beats a clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ChangeLatched <= 1'b0;
        end else if (AnyChange) begin
            ChangeLatched <= 1'b1;
        end else if (ClearChange) begin
            ChangeLatched <= 1'b0;
        end
    end

endmodule

// File: tb/tb_port_in_debouncer.sv
// Directed bench for port_in_debouncer with debounce counts 4 and 1.
// Outputs are sampled 1 time unit after each rising edge.
module tb_port_in_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rawIn0, rawIn1;
    logic       clr0, clr1;
    logic [7:0] portIn0, pulse0, portIn1, pulse1;
    logic       any0, latched0, any1, latched1;

    int nCmp = 0;
    int nBad = 0;
    logic lvl;

    always #5 clk = ~clk;

    port_in_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(4)) uDut4 (
        .clk          (clk),
        .reset        (reset),
        .RawIn        (rawIn0),
        .ClearChange  (clr0),
        .PortIn       (portIn0),
        .ChangePulse  (pulse0),
        .AnyChange    (any0),
        .ChangeLatched(latched0)
    );

    port_in_debouncer #(.NBITS(8), .DEBOUNCE_CYCLES(1)) uDut1 (
        .clk          (clk),
        .reset        (reset),
        .RawIn        (rawIn1),
        .ClearChange  (clr1),
        .PortIn       (portIn1),
        .ChangePulse  (pulse1),
        .AnyChange    (any1),
        .ChangeLatched(latched1)
    );

    task automatic checkVal(input string tag, input logic [7:0] got,
                            input logic [7:0] exp);
        nCmp++;
        if (got !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic stepEdge(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        rawIn0 = 8'hFF;
        rawIn1 = 8'h00;
        clr0   = 1'b0;
        clr1   = 1'b0;

        // 1. reset with inputs high
        stepEdge(3);
        checkVal("rst.portIn", portIn0, 8'h00);
        checkVal("rst.pulse", pulse0, 8'h00);
        checkVal("rst.any", {7'b0, any0}, 8'h00);
        checkVal("rst.latched", {7'b0, latched0}, 8'h00);
        reset = 1'b1;
        stepEdge(5);
        checkVal("rel.e4.portIn", portIn0, 8'h00);
        stepEdge();
        checkVal("rel.e5.portIn", portIn0, 8'hFF);
        checkVal("rel.e5.pulse", pulse0, 8'hFF);
        checkVal("rel.e5.any", {7'b0, any0}, 8'h01);
        stepEdge();
        checkVal("rel.e6.pulse", pulse0, 8'h00);
        checkVal("rel.e6.latched", {7'b0, latched0}, 8'h01);

        // async assertion clears outputs before the next edge
        rawIn0 = 8'h00;
        reset  = 1'b0;
        #1;
        checkVal("async.portIn", portIn0, 8'h00);
        checkVal("async.latched", {7'b0, latched0}, 8'h00);
        stepEdge(2);
        reset = 1'b1;
        stepEdge(2);

        // 2. glitch of 3 synchronized cycles is rejected
        rawIn0[3] = 1'b1;
        stepEdge(3);
        rawIn0[3] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            stepEdge();
            checkVal("glitch.portIn", portIn0, 8'h00);
            checkVal("glitch.pulse", pulse0, 8'h00);
        end
        checkVal("glitch.latched", {7'b0, latched0}, 8'h00);

        // 3. held change on bit 0
        rawIn0[0] = 1'b1;
        stepEdge(5);
        checkVal("held.e4.portIn", portIn0, 8'h00);
        stepEdge();
        checkVal("held.e5.portIn", portIn0, 8'h01);
        checkVal("held.e5.pulse", pulse0, 8'h01);
        stepEdge();
        checkVal("held.e6.pulse", pulse0, 8'h00);
        checkVal("held.e6.latched", {7'b0, latched0}, 8'h01);
        for (int i = 0; i < 10; i++) begin
            stepEdge();
            checkVal("held.quiet", pulse0, 8'h00);
        end
        checkVal("held.portIn", portIn0, 8'h01);

        // 4. clear alone, then clear colliding with a change
        clr0 = 1'b1;
        stepEdge();
        clr0 = 1'b0;
        checkVal("clr.alone", {7'b0, latched0}, 8'h00);
        rawIn0[1] = 1'b1;
        stepEdge(6);
        checkVal("clr.e5.pulse", pulse0, 8'h02);
        checkVal("clr.e5.latched", {7'b0, latched0}, 8'h00);
        clr0 = 1'b1;
        stepEdge();
        clr0 = 1'b0;
        checkVal("clr.collide", {7'b0, latched0}, 8'h01);
        stepEdge();
        checkVal("clr.after", {7'b0, latched0}, 8'h01);

        // 5. reset in the middle of a count on bit 7
        rawIn0[7] = 1'b1;
        stepEdge(4);
        reset = 1'b0;
        #1;
        checkVal("mid.rst.portIn", portIn0, 8'h00);
        stepEdge(2);
        checkVal("mid.hold.portIn", portIn0, 8'h00);
        reset = 1'b1;
        stepEdge(5);
        checkVal("mid.e4.portIn", portIn0, 8'h00);
        stepEdge();
        checkVal("mid.e5.portIn", portIn0, 8'h83);
        checkVal("mid.e5.pulse", pulse0, 8'h83);

        // 6. count of 1: toggle bit 2 every 4 clocks
        lvl = 1'b0;
        checkVal("d1.start", portIn1, 8'h00);
        for (int t = 0; t < 4; t++) begin
            lvl = ~lvl;
            rawIn1[2] = lvl;
            stepEdge(2);
            checkVal("d1.e1.portIn", portIn1, {5'b0, ~lvl, 2'b0});
            checkVal("d1.e1.pulse", pulse1, 8'h00);
            stepEdge();
            checkVal("d1.e2.portIn", portIn1, {5'b0, lvl, 2'b0});
            checkVal("d1.e2.pulse", pulse1, 8'h04);
            stepEdge();
            checkVal("d1.e3.pulse", pulse1, 8'h00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 nCmp, nBad);
        $finish;
    end

endmodule
